// File: rtl/pwm_reg_scheduler.sv
// pwm_reg_scheduler: two-requester register write arbiter with shadow/active
// register banks. Accepted writes land in the shadow bank. The shadow bank is
// copied to the active bank only on a PWM period boundary, or when a pending
// commit has waited too long for one.
module pwm_reg_scheduler #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 5,
   parameter int MAX_WAIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              period_end,
   output logic [DATA_W-1:0] en_out,
   output logic [DATA_W-1:0] en_uio,
   output logic [DATA_W-1:0] pwm_out,
   output logic [DATA_W-1:0] pwm_uio,
   output logic [DATA_W-1:0] duty,
   output logic              pending,
   output logic              addr_err
);

   // The wait counter only ever needs to reach MAX_WAIT-1.
   localparam int                CNT_W      = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_WAIT - 1);
   localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
   localparam int                NUM_VIEW   = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   state_t                          state, state_nxt;
   logic [CNT_W-1:0]                wait_cnt;
   logic                            rr_ptr;       // 0: A wins a tie, 1: B wins a tie
   logic                            elig_a, elig_b;
   logic                            gnt_a, gnt_b, gnt_any;
   logic                            addr_ok, wr_hit;
   wr_req_t                         req_sel;
   logic [NUM_REGS-1:0][DATA_W-1:0] shadow;
   logic [NUM_REGS-1:0][DATA_W-1:0] active;
   logic [NUM_VIEW-1:0][DATA_W-1:0] act_view;

   // Round-robin grant. A requester whose ready pulse is still in flight is
   // holding a request that has already been taken, so it sits out.
   always_comb begin
      elig_a  = a_valid && !a_ready;
      elig_b  = b_valid && !b_ready;
      gnt_a   = elig_a && (!elig_b || !rr_ptr);
      gnt_b   = elig_b && (!elig_a ||  rr_ptr);
      gnt_any = gnt_a || gnt_b;
      req_sel.addr = a_addr;
      req_sel.data = a_data;
      if (gnt_b) begin
         req_sel.addr = b_addr;
         req_sel.data = b_data;
      end
      addr_ok = ({1'b0, req_sel.addr} < NUM_REGS_W);
      wr_hit  = gnt_any && addr_ok;
   end

   // Registered ready/addr_err pulses and the tie-break pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_ready  <= 1'b0;
         b_ready  <= 1'b0;
         addr_err <= 1'b0;
         rr_ptr   <= 1'b0;
      end else begin
         a_ready  <= gnt_a;
         b_ready  <= gnt_b;
         addr_err <= gnt_any && !addr_ok;
         if (gnt_a)      rr_ptr <= 1'b1;
         else if (gnt_b) rr_ptr <= 1'b0;
      end
   end

   // Shadow bank takes the granted write at the end of the grant cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (wr_hit) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (req_sel.addr == ADDR_W'(i)) shadow[i] <= req_sel.data;
         end
      end
   end

   // Active bank only moves in COMMIT; a write granted during COMMIT is in
   // the shadow too late to be copied and waits for the next boundary.
   always_ff @(posedge clk) begin
      if (rst)                  active <= '0;
      else if (state == COMMIT) active <= shadow;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic. Bad-address writes never open a commit window.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (wr_hit) state_nxt = PENDING;
         PENDING: if (period_end || (wait_cnt == CNT_LAST)) state_nxt = COMMIT;
         COMMIT:  state_nxt = wr_hit ? PENDING : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Wait counter: counts while pending, saturates, cleared outside PENDING.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state == PENDING) begin
         if (wait_cnt != CNT_LAST) wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Shadow differs from active until the COMMIT edge has happened.
   assign pending = (state != IDLE);

   // Map the active bank onto the fixed output set; absent registers read 0.
   for (genvar k = 0; k < NUM_VIEW; k++) begin : g_view
      if (k < NUM_REGS) begin : g_on
         assign act_view[k] = active[k];
      end else begin : g_off
         assign act_view[k] = '0;
      end
   end

   assign en_out  = act_view[0];
   assign en_uio  = act_view[1];
   assign pwm_out = act_view[2];
   assign pwm_uio = act_view[3];
   assign duty    = act_view[4];

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// Directed bench for pwm_reg_scheduler: a main instance with default
// parameters plus a MAX_WAIT=16 instance for the forced-commit case.
// Expected ready/commit results are queued when stimulus is driven and
// popped when the DUT responds.
module tb_pwm_reg_scheduler;
   localparam int AW = 7;
   localparam int DW = 8;
   localparam int NR = 5;

   typedef logic [4:0][7:0] regs_t;
   typedef struct {
      bit is_b;
      bit err;
   } rdy_exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, a_valid, b_valid, period_end;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_ready, b_ready, pending, addr_err;
   logic [7:0]    en_out, en_uio, pwm_out, pwm_uio, duty;
   logic          t_a_ready, t_b_ready, t_pending, t_addr_err;
   logic [7:0]    t_en_out, t_en_uio, t_pwm_out, t_pwm_uio, t_duty;

   int       total = 0;
   int       bad   = 0;
   regs_t    model_shadow, model_active;
   regs_t    exp_q[$];
   rdy_exp_t rdy_q[$];
   bit       ord_q[$];

   pwm_reg_scheduler dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .period_end(period_end),
      .en_out(en_out), .en_uio(en_uio), .pwm_out(pwm_out), .pwm_uio(pwm_uio),
      .duty(duty), .pending(pending), .addr_err(addr_err)
   );

   pwm_reg_scheduler #(.MAX_WAIT(16)) dut16 (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(t_a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(t_b_ready),
      .period_end(period_end),
      .en_out(t_en_out), .en_uio(t_en_uio), .pwm_out(t_pwm_out), .pwm_uio(t_pwm_uio),
      .duty(t_duty), .pending(t_pending), .addr_err(t_addr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input regs_t e);
      chk({tag, "_en_out"},  en_out,  e[0]);
      chk({tag, "_en_uio"},  en_uio,  e[1]);
      chk({tag, "_pwm_out"}, pwm_out, e[2]);
      chk({tag, "_pwm_uio"}, pwm_uio, e[3]);
      chk({tag, "_duty"},    duty,    e[4]);
   endtask

   // Called at a negedge; leaves rst low at the following negedge.
   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      model_shadow = '0;
      model_active = '0;
   endtask

   // Single-requester write: drive, wait (bounded) for the ready pulse, check
   // it against the queued expectation, release the request.
   task automatic wr(input bit is_b, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      rdy_exp_t e;
      bit got;
      if (is_b) begin b_valid = 1'b1; b_addr = ad; b_data = d; end
      else      begin a_valid = 1'b1; a_addr = ad; a_data = d; end
      e.is_b = is_b;
      e.err  = (ad >= NR);
      rdy_q.push_back(e);
      if (ad < NR) model_shadow[ad[2:0]] = d;
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         if (a_ready || b_ready) got = 1'b1;
      end
      chk("wr_ready_seen", got, 1);
      e = rdy_q.pop_front();
      if (got) begin
         chk("wr_a_ready", a_ready,  !e.is_b);
         chk("wr_b_ready", b_ready,  e.is_b);
         chk("wr_addr_err", addr_err, e.err);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   // period_end in cycle M: active unchanged in M+1, equals the shadow
   // snapshot from M in M+2, pending low by then.
   task automatic commit_pulse(input string tag);
      regs_t snap;
      period_end = 1'b1;
      exp_q.push_back(model_shadow);
      @(negedge clk);
      period_end = 1'b0;
      chk_all({tag, "_hold"}, model_active);
      @(negedge clk);
      snap = exp_q.pop_front();
      chk_all(tag, snap);
      chk({tag, "_pending"}, pending, 0);
      model_active = snap;
   endtask

   initial begin
      int    first, second;
      bit    e;
      regs_t snap;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; period_end = 1'b0;
      a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
      model_shadow = '0; model_active = '0;

      // Reset: two reset edges, then quiet outputs.
      @(negedge clk);
      do_reset(2);
      repeat (3) begin
         @(negedge clk);
         chk_all("rst", '0);
         chk("rst_pending", pending, 0);
         chk("rst_ready", {a_ready, b_ready, addr_err}, 0);
      end

      // Deferred commit: duty only moves two cycles after period_end.
      wr(1'b0, 7'h04, 8'h80);
      chk("def_pending", pending, 1);
      chk("def_duty_early", duty, 8'h00);
      repeat (19) begin
         @(negedge clk);
         chk("def_duty_wait", duty, 8'h00);
         chk("def_pend_wait", pending, 1);
      end
      commit_pulse("def");

      // Contention from reset: A first, B within 3 cycles of A.
      do_reset(1);
      a_valid = 1'b1; a_addr = 7'h00; a_data = 8'hFF;
      b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h0F;
      model_shadow[0] = 8'hFF;
      model_shadow[1] = 8'h0F;
      ord_q.push_back(1'b0);
      ord_q.push_back(1'b1);
      first = -1; second = -1;
      for (int c = 1; c <= 8 && ord_q.size() > 0; c++) begin
         @(negedge clk);
         if (a_ready || b_ready) begin
            e = ord_q.pop_front();
            chk("cont_order", {a_ready, b_ready}, e ? 2'b01 : 2'b10);
            if (a_ready) a_valid = 1'b0;
            if (b_ready) b_valid = 1'b0;
            if (first < 0) first = c;
            else           second = c;
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      chk("cont_first_cycle", first, 1);
      chk("cont_gap_le3", (second > first) && (second - first <= 3), 1);
      chk("cont_pending", pending, 1);
      commit_pulse("cont");

      // Bad address from B: ready + addr_err together, nothing else moves.
      wr(1'b1, 7'h05, 8'hAA);
      chk("bad_pending", pending, 0);
      chk_all("bad_hold", model_active);
      @(negedge clk);
      chk("bad_pending_later", pending, 0);
      chk("bad_err_one_cycle", addr_err, 0);
      chk_all("bad_hold_later", model_active);

      // Forced commit on the MAX_WAIT=16 instance, 17 cycles after entry.
      do_reset(1);
      wr(1'b0, 7'h02, 8'h01);
      exp_q.push_back(model_shadow);
      chk("tmo_pending", t_pending, 1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk("tmo_pwm_wait", t_pwm_out, 8'h00);
      end
      @(negedge clk);
      snap = exp_q.pop_front();
      chk("tmo_pwm_commit", t_pwm_out, snap[2]);
      chk("tmo_pending_low", t_pending, 0);
      chk("tmo_main_no_force", pwm_out, 8'h00);
      chk("tmo_main_pending", pending, 1);
      commit_pulse("tmo_main");

      // Reset while pending drops the shadow data.
      wr(1'b0, 7'h04, 8'h40);
      chk("rmp_pending", pending, 1);
      do_reset(1);
      chk("rmp_pending_cleared", pending, 0);
      chk_all("rmp_after_rst", '0);
      commit_pulse("rmp_post");
      chk("rmp_duty_final", duty, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pwm_reg_scheduler.md
Name: pwm_reg_scheduler

Overview:
- Sits between the SPI register-write path and the PWM/output-enable datapath inside the onboarding top level.
- Arbitrates register writes from two requesters: A is the SPI peripheral, B is a debug/config port.
- Buffers accepted writes in shadow registers and commits them to the active registers only at a PWM period boundary, so duty and enable changes never glitch mid-period.
- A timeout forces the commit if no boundary arrives.

Parameters:
ADDR_W, 7, register address width
DATA_W, 8, register data width
NUM_REGS, 5, number of implemented registers (addresses 0x00..NUM_REGS-1)
MAX_WAIT, 1024, cycles a pending commit may wait for period_end before it is forced

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
a_valid  in  1  requester A write request
a_addr  in  ADDR_W  requester A register address
a_data  in  DATA_W  requester A write data
a_ready  out  1  requester A write accepted (1-cycle pulse)
b_valid  in  1  requester B write request
b_addr  in  ADDR_W  requester B register address
b_data  in  DATA_W  requester B write data
b_ready  out  1  requester B write accepted (1-cycle pulse)
period_end  in  1  PWM counter wrap pulse
en_out  out  8  active reg 0x00 (uo_out enables)
en_uio  out  8  active reg 0x01 (uio_out enables)
pwm_out  out  8  active reg 0x02 (uo_out PWM select)
pwm_uio  out  8  active reg 0x03 (uio_out PWM select)
duty  out  8  active reg 0x04 (duty cycle)
pending  out  1  shadow holds uncommitted writes
addr_err  out  1  1-cycle pulse, write to unimplemented address dropped

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - all shadow and active registers become 0x00
  - pending=0, a_ready=b_ready=0, addr_err=0
  - wait counter = 0, round-robin pointer = A
  - reset during a pending commit discards the pending data.
- Arbitration:
  - At most one write is accepted per cycle.
  - If only one valid is high, that requester is granted.
  - If both are high, the pointer picks the winner. The pointer moves to the other requester after every grant.
  - Valid, addr and data must be held stable until ready. Ready is a registered 1-cycle pulse asserted in the cycle after the grant decision. No new grant is made to a requester while its ready pulse is outstanding.
  - Starvation bound: a continuously-valid requester is granted within 3 cycles.
- Write effect:
  - Granted addr < NUM_REGS: the shadow register is updated at the edge ending the grant cycle.
  - Addr >= NUM_REGS: ready still pulses, data is dropped, addr_err pulses aligned with ready, pending is unchanged.
  - Writing a value equal to the current shadow still sets pending.
- FSM states:
  - IDLE: pending=0, counter held at 0. Valid write -> PENDING.
  - PENDING: pending=1, counter increments each cycle. period_end=1 or counter=MAX_WAIT-1 -> COMMIT.
  - COMMIT (1 cycle): active <= shadow. Then go to PENDING if a write was granted during COMMIT, else IDLE. Counter resets to 0.
- Latency:
  - period_end in cycle M puts the FSM in COMMIT in cycle M+1.
  - Active outputs change at the end of M+1, i.e. are visible from M+2.
  - pending falls the same cycle.
- Simultaneous events:
  - A write granted in the same cycle as period_end is included in the shadow captured by COMMIT.
  - A write granted during COMMIT is not included in that commit; it sets pending for the next boundary.
  - period_end in IDLE is ignored.
- Active outputs change only in COMMIT.
- No arithmetic wrap is possible: the counter saturates at MAX_WAIT-1 and is cleared by COMMIT.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then release -> all five outputs 0x00, pending=0, no ready pulses.
- Deferred commit: A writes 0x04=0x80, then period_end arrives 20 cycles later -> a_ready pulses once, pending=1, duty stays 0x00 until 2 cycles after period_end, then duty=0x80 and pending=0.
- Contention: A (0x00=0xFF) and B (0x01=0x0F) valid together from reset -> A granted first, B granted next, at most 3 cycles after the first grant; after period_end, en_out=0xFF and en_uio=0x0F.
- Bad address: B writes 0x05=0xAA -> b_ready and addr_err pulse together; pending stays 0 and all outputs are unchanged.
- Timeout: with MAX_WAIT=16, A writes 0x02=0x01 and period_end is held low -> commit is forced, pwm_out=0x01 exactly 17 cycles after the PENDING entry.
- Reset mid-pending: A writes 0x04=0x40, then rst=1 before period_end -> duty=0x00 and pending=0, and a later period_end leaves duty at 0x00.
